// File: rtl/clip_player.sv
// Clip player: steps a ROM address through a selected clip at one sample per DIV
// clocks and presents MSB-aligned samples to an audio codec write port.
//
// state | meaning
// IDLE  | no clip active, waiting for a play pulse
// PLAY  | stepping rom_addr from start to end, emitting one sample per tick
module clip_player #(
  parameter int ADDR_W    = 18,
  parameter int SAMPLE_W  = 6,
  parameter int OUT_W     = 32,
  parameter int NUM_CLIPS = 4,
  parameter int SEL_W     = 2,
  parameter int DIV       = 1200
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        play,
  input  logic                        stop,
  input  logic                        loop_en,
  input  logic [SEL_W-1:0]            clip_sel,
  input  logic [NUM_CLIPS*2*ADDR_W-1:0] clip_bounds,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [SAMPLE_W-1:0]         rom_q,
  input  logic                        audio_out_allowed,
  output logic [OUT_W-1:0]            sample_out,
  output logic                        sample_valid,
  output logic                        write_audio_out,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   rom_addr_nxt;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
  logic [ADDR_W-1:0]   start_r, start_nxt;
  logic [ADDR_W-1:0]   end_r, end_nxt;
  logic [OUT_W-1:0]    sample_out_nxt;
  logic                sample_valid_nxt;
  logic                first_loaded, first_loaded_nxt;
  logic                done_nxt;
  logic                err_nxt;

  logic [ADDR_W-1:0]   sel_start;
  logic [ADDR_W-1:0]   sel_end;
  logic                sel_in_range;
  logic                play_ok;
  logic                tick;

  // Selected table entry; out-of-range selections leave sel_in_range low.
  always_comb begin
    sel_start    = '0;
    sel_end      = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (clip_sel == SEL_W'(i)) begin
        sel_start    = clip_bounds[i*2*ADDR_W +: ADDR_W];
        sel_end      = clip_bounds[i*2*ADDR_W + ADDR_W +: ADDR_W];
        sel_in_range = 1'b1;
      end
    end
  end

  assign play_ok = sel_in_range && (sel_start <= sel_end);
  assign tick    = (div_cnt == DIV_W'(DIV - 1));

  always_comb begin
    state_nxt        = state;
    rom_addr_nxt     = rom_addr;
    div_cnt_nxt      = div_cnt;
    start_nxt        = start_r;
    end_nxt          = end_r;
    sample_out_nxt   = sample_out;
    sample_valid_nxt = 1'b0;
    first_loaded_nxt = first_loaded;
    done_nxt         = 1'b0;
    err_nxt          = 1'b0;

    case (state)
      IDLE: begin
        if (play) begin
          if (play_ok) begin
            start_nxt        = sel_start;
            end_nxt          = sel_end;
            rom_addr_nxt     = sel_start;
            div_cnt_nxt      = '0;
            first_loaded_nxt = 1'b0;
            state_nxt        = PLAY;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      PLAY: begin
        if (stop) begin
          state_nxt        = IDLE;
          sample_out_nxt   = '0;
          first_loaded_nxt = 1'b0;
          div_cnt_nxt      = '0;
        end else if (play && play_ok) begin
          start_nxt        = sel_start;
          end_nxt          = sel_end;
          rom_addr_nxt     = sel_start;
          div_cnt_nxt      = '0;
          first_loaded_nxt = 1'b0;
        end else begin
          err_nxt = play;
          // ROM data for the current address is valid one cycle after div_cnt==0.
          if (div_cnt == DIV_W'(1)) begin
            sample_out_nxt   = {rom_q, {(OUT_W-SAMPLE_W){1'b0}}};
            sample_valid_nxt = 1'b1;
            first_loaded_nxt = 1'b1;
          end
          if (tick) begin
            div_cnt_nxt = '0;
            // End compare comes first so an all-ones end address never wraps.
            if (rom_addr < end_r) begin
              rom_addr_nxt = rom_addr + ADDR_W'(1);
            end else if (loop_en) begin
              rom_addr_nxt = start_r;
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state        <= IDLE;
      rom_addr     <= '0;
      div_cnt      <= '0;
      start_r      <= '0;
      end_r        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      first_loaded <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      rom_addr     <= rom_addr_nxt;
      div_cnt      <= div_cnt_nxt;
      start_r      <= start_nxt;
      end_r        <= end_nxt;
      sample_out   <= sample_out_nxt;
      sample_valid <= sample_valid_nxt;
      first_loaded <= first_loaded_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

  assign busy            = (state == PLAY);
  assign write_audio_out = (state == PLAY) && audio_out_allowed && first_loaded;

endmodule

// File: tb/tb_clip_player.sv
// Directed bench for clip_player: DIV=4, four clips, behavioural 1-cycle ROM.
module tb_clip_player;

  localparam int ADDR_W = 18, SAMPLE_W = 6, OUT_W = 32, NUM_CLIPS = 4, SEL_W = 3, DIV = 4;

  logic                          CLOCK_50 = 1'b0;
  logic                          resetn, play, stop, loop_en, audio_out_allowed;
  logic [SEL_W-1:0]              clip_sel;
  logic [NUM_CLIPS*2*ADDR_W-1:0] clip_bounds;
  logic [ADDR_W-1:0]             rom_addr;
  logic [SAMPLE_W-1:0]           rom_q;
  logic [OUT_W-1:0]              sample_out;
  logic                          sample_valid, write_audio_out, busy, done, err;

  int checks = 0;
  int errors = 0;

  clip_player #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W),
                .NUM_CLIPS(NUM_CLIPS), .SEL_W(SEL_W), .DIV(DIV)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .play(play), .stop(stop), .loop_en(loop_en),
    .clip_sel(clip_sel), .clip_bounds(clip_bounds), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(audio_out_allowed), .sample_out(sample_out),
    .sample_valid(sample_valid), .write_audio_out(write_audio_out), .busy(busy),
    .done(done), .err(err));

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [SAMPLE_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    if (a == 18'd10) return 6'b101101;
    return a[5:0] ^ 6'h15;
  endfunction

  always @(posedge CLOCK_50) rom_q <= rom_f(rom_addr);

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic start_clip(input logic [SEL_W-1:0] sel);
    clip_sel = sel;
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    checks++;
    if ({rom_addr, sample_out, sample_valid, write_audio_out, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual=%0h expected=0", {rom_addr, sample_out, busy, done, err});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_play_once();
    loop_en = 1'b0;
    start_clip(3'd1);
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (cyc < 12) chk("once_addr", 64'(rom_addr), 64'(10 + cyc / 4));
      chk("once_valid", 64'(sample_valid), 64'(cyc % 4 == 2));
      chk("once_done", 64'(done), 64'(cyc == 12));
      chk("once_busy", 64'(busy), 64'(cyc < 12));
      if (cyc == 2)  chk("once_sample10", 64'(sample_out), 64'h0000_0000_B400_0000);
      if (cyc == 6)  chk("once_sample11", 64'(sample_out), 64'({6'd11 ^ 6'h15, 26'd0}));
      if (cyc == 10) chk("once_sample12", 64'(sample_out), 64'({6'd12 ^ 6'h15, 26'd0}));
      if (cyc < 12) step();
    end
    step();
    chk("once_done_clear", 64'(done), 64'd0);
  endtask

  task automatic test_loop();
    int addr_seq[5] = '{10, 11, 12, 10, 11};
    loop_en = 1'b1;
    start_clip(3'd1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      chk("loop_addr", 64'(rom_addr), 64'(addr_seq[cyc / 4]));
      chk("loop_done", 64'(done), 64'd0);
      chk("loop_busy", 64'(busy), 64'd1);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("loop_stop_busy", 64'(busy), 64'd0);
    chk("loop_stop_sample", 64'(sample_out), 64'd0);
    loop_en = 1'b0;
    step();
  endtask

  task automatic test_err();
    start_clip(3'd5);
    chk("err_sel_pulse", 64'(err), 64'd1);
    chk("err_sel_busy", 64'(busy), 64'd0);
    step();
    chk("err_sel_clear", 64'(err), 64'd0);
    start_clip(3'd2);
    chk("err_order_pulse", 64'(err), 64'd1);
    chk("err_order_busy", 64'(busy), 64'd0);
    step();
    chk("err_order_clear", 64'(err), 64'd0);
  endtask

  task automatic test_stop_play();
    start_clip(3'd1);
    repeat (5) step();
    stop = 1'b1;
    play = 1'b1;
    step();
    stop = 1'b0;
    play = 1'b0;
    chk("sp_busy", 64'(busy), 64'd0);
    chk("sp_sample", 64'(sample_out), 64'd0);
    chk("sp_done", 64'(done), 64'd0);
    step();
    chk("sp_done2", 64'(done), 64'd0);
    chk("sp_idle", 64'(busy), 64'd0);
  endtask

  task automatic test_write_strobe();
    audio_out_allowed = 1'b1;
    start_clip(3'd1);
    chk("wr_before_first", 64'(write_audio_out), 64'd0);
    step();
    chk("wr_before_first2", 64'(write_audio_out), 64'd0);
    step();
    chk("wr_after_first", 64'(write_audio_out), 64'd1);
    audio_out_allowed = 1'b0;
    #1;
    chk("wr_blocked", 64'(write_audio_out), 64'd0);
    chk("wr_hold_sample", 64'(sample_out), 64'h0000_0000_B400_0000);
    audio_out_allowed = 1'b1;
    #1;
    chk("wr_resume", 64'(write_audio_out), 64'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("wr_after_stop", 64'(write_audio_out), 64'd0);
    audio_out_allowed = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_clip(3'd1);
    step(); step();
    resetn = 1'b0;
    step();
    checks++;
    if ({rom_addr, sample_out, sample_valid, write_audio_out, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid actual=%0h expected=0", {rom_addr, sample_out, busy, done, err});
    end
    resetn = 1'b1;
    start_clip(3'd1);
    chk("reset_restart_addr", 64'(rom_addr), 64'd10);
    chk("reset_restart_busy", 64'(busy), 64'd1);
    chk("reset_no_done", 64'(done), 64'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_single_and_retrigger();
    start_clip(3'd3);
    for (int cyc = 0; cyc < 4; cyc++) begin
      chk("single_addr", 64'(rom_addr), 64'd30);
      step();
    end
    chk("single_done", 64'(done), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);
    step();
    start_clip(3'd1);
    repeat (11) step();
    clip_sel = 3'd3;
    play = 1'b1;
    step();
    play = 1'b0;
    chk("retrig_addr", 64'(rom_addr), 64'd30);
    chk("retrig_busy", 64'(busy), 64'd1);
    chk("retrig_no_done", 64'(done), 64'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_max_addr();
    start_clip(3'd0);
    chk("max_addr0", 64'(rom_addr), 64'h3FFFE);
    repeat (4) step();
    chk("max_addr1", 64'(rom_addr), 64'h3FFFF);
    repeat (4) step();
    chk("max_done", 64'(done), 64'd1);
    chk("max_addr_hold", 64'(rom_addr), 64'h3FFFF);
    step();
  endtask

  initial begin
    resetn = 1'b0; play = 1'b0; stop = 1'b0; loop_en = 1'b0;
    audio_out_allowed = 1'b0; clip_sel = '0;
    clip_bounds = {18'd30, 18'd30, 18'd15, 18'd20, 18'd12, 18'd10, 18'h3FFFF, 18'h3FFFE};
    #1;
    test_reset();
    test_play_once();
    test_loop();
    test_err();
    test_stop_play();
    test_write_strobe();
    test_reset_mid();
    test_single_and_retrigger();
    test_max_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clip_player.md
CLIP_PLAYER -- requirements
Module: clip_player

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 18, ROM address width; SAMPLE_W, default 6, ROM sample width; OUT_W, default 32, codec word width; NUM_CLIPS, default 4, clip table entries; SEL_W, default 2, clip_sel width; DIV, default 1200, clocks per sample (legal DIV>=3).
REQ-002 The block SHALL use one clock and one reset; the reset is synchronous and active-low.
REQ-003 Port CLOCK_50, in, 1: system clock, all logic on the rising edge.
REQ-004 Port resetn, in, 1: synchronous active-low reset.
REQ-005 Port play, in, 1: start pulse.
REQ-006 Port stop, in, 1: abort request.
REQ-007 Port loop_en, in, 1: loop mode, sampled continuously.
REQ-008 Port clip_sel, in, SEL_W: clip index.
REQ-009 Port clip_bounds, in, NUM_CLIPS*2*ADDR_W: entry i = {end_i, start_i}, start_i in the low ADDR_W bits.
REQ-010 Port rom_addr, out, ADDR_W: registered ROM address.
REQ-011 Port rom_q, in, SAMPLE_W: synchronous ROM data, 1-cycle latency.
REQ-012 Port audio_out_allowed, in, 1: codec FIFO has space.
REQ-013 Port sample_out, out, OUT_W: {rom_q, zeros}, MSB-aligned.
REQ-014 Port sample_valid, out, 1: one-cycle pulse when sample_out updates.
REQ-015 Port write_audio_out, out, 1: codec write strobe.
REQ-016 Ports busy, done and err, out, 1 each: busy is high when not IDLE; done and err are one-cycle pulses.

Function
REQ-017 The FSM SHALL have two states: IDLE and PLAY.
REQ-018 In IDLE, a play pulse with clip_sel < NUM_CLIPS and start <= end SHALL latch start/end, set rom_addr=start and div_cnt=0, and enter PLAY on the next edge.
REQ-019 In IDLE, a play pulse with clip_sel >= NUM_CLIPS or start > end SHALL pulse err for one cycle and stay in IDLE.
REQ-020 In PLAY, div_cnt SHALL count 0..DIV-1 and wrap to 0; each wrap is a tick.
REQ-021 On a tick with rom_addr < end, rom_addr SHALL increment by 1.
REQ-022 On a tick with rom_addr == end and loop_en=1, rom_addr SHALL load start, with no gap sample.
REQ-023 On a tick with rom_addr == end and loop_en=0, the FSM SHALL go to IDLE and pulse done for one cycle; the last sample SHALL already have been emitted.
REQ-024 On the edge where div_cnt==1, sample_out SHALL load {rom_q, OUT_W-SAMPLE_W zeros}, and sample_valid SHALL be high in the following cycle; the latency from rom_addr change to the new sample_out SHALL be 2 clocks.
REQ-025 write_audio_out SHALL equal (state==PLAY) AND audio_out_allowed AND first_sample_loaded; the block SHALL hold the current sample and never stall on backpressure.
REQ-026 A stop asserted in PLAY SHALL force IDLE on the next edge, clear sample_out to 0, and not pulse done.
REQ-027 A play pulse in PLAY SHALL retrigger: it re-latches bounds from the current clip_sel, sets rom_addr=start, div_cnt=0 and clears first_sample_loaded; an invalid retrigger SHALL pulse err and continue the current clip.
REQ-028 When stop and play are asserted in the same cycle, stop SHALL win.
REQ-029 When a tick end-condition coincides with play, play SHALL win; done SHALL not pulse.
REQ-030 Changes to clip_sel or clip_bounds during PLAY SHALL be ignored until the next play.
REQ-031 A clip with start == end SHALL play one sample, then done (or repeat that sample if loop_en=1).
REQ-032 The address arithmetic SHALL be ADDR_W-bit unsigned; end = 2^ADDR_W-1 SHALL not overflow, because the end compare precedes the increment.

Reset
REQ-033 While resetn=0 at a clock edge, the block SHALL set state=IDLE, rom_addr=0, div_cnt=0, sample_out=0, first_sample_loaded=0, and drive sample_valid, write_audio_out, busy, done and err to 0.
REQ-034 Reset mid-PLAY SHALL abandon the clip with no done pulse; the block SHALL accept play in the first cycle after resetn=1.

Verification
REQ-035 Bench DIV=4, clip1={end=12,start=10}, loop_en=0, play pulse -> rom_addr 10,11,12 each held 4 clocks; three sample_valid pulses; done 1 cycle; busy falls.
REQ-036 Same setup with loop_en=1 -> rom_addr sequence 10,11,12,10,11 with no idle gap; done never asserted.
REQ-037 clip_sel=5 with NUM_CLIPS=4, or an entry with start=20,end=15, then play -> err pulse; busy stays 0.
REQ-038 stop and play in the same cycle mid-clip -> IDLE next cycle; sample_out=0; no done.
REQ-039 rom_q=6'b101101 at addr 10 -> sample_out=32'hB4000000 two clocks after rom_addr=10; write_audio_out follows audio_out_allowed toggling.
REQ-040 resetn=0 at div_cnt=2 mid-clip -> all outputs 0 next edge; play after release starts cleanly at start.
